// File: rtl/output_writeback.sv
// Result write-back stage: buffers chip results in a FIFO, computes feature-map addresses
// and drains them to a ready/valid memory write port. Optional macro: OUTPUT_WRITEBACK_RELU_EN.
module output_writeback #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 8,
  parameter int ADDR_WIDTH         = 32,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_in,
  input  logic                                  start,
  input  logic                                  chip_running,
  input  logic signed [IO_DATA_WIDTH-1:0]       in_data,
  input  logic                                  in_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  in_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] in_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] in_ch,
  output logic                                  mem_we,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [IO_DATA_WIDTH-1:0]              mem_wdata,
  input  logic                                  mem_ready,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow,
  output logic [CNT_WIDTH-1:0]                  write_count,
  output logic [CNT_WIDTH-1:0]                  drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] FMW = ADDR_WIDTH'(FEATURE_MAP_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] NCH = ADDR_WIDTH'(OUTPUT_NB_CHANNELS);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

  state_t state, state_next;
  logic   running_seen, seen_next;

  logic [PW:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic        fifo_empty, fifo_full;
  logic        push_req, push_accept, push_drop, pop;

  logic [ADDR_WIDTH-1:0]    push_addr;
  logic [IO_DATA_WIDTH-1:0] push_data;

  logic [ADDR_WIDTH-1:0]    addr_mem [FIFO_DEPTH];
  logic [IO_DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign pop         = !fifo_empty && mem_ready;
  assign push_req    = in_valid && (state == S_ACTIVE || state == S_DRAIN);
  assign push_accept = push_req && (!fifo_full || pop);
  assign push_drop   = push_req && fifo_full && !pop;

  assign wr_ptr_next = wr_ptr + (PW+1)'(push_accept);
  assign rd_ptr_next = rd_ptr + (PW+1)'(pop);

  assign push_addr = ((ADDR_WIDTH'(in_y) * FMW) + ADDR_WIDTH'(in_x)) * NCH + ADDR_WIDTH'(in_ch);

`ifdef OUTPUT_WRITEBACK_RELU_EN
  assign push_data = in_data[IO_DATA_WIDTH-1] ? '0 : in_data;
`else
  assign push_data = in_data;
`endif

  // Outputs are forced to zero while empty so stale storage never shows on the port.
  assign mem_we    = !fifo_empty;
  assign mem_addr  = fifo_empty ? '0 : addr_mem[rd_ptr[PW-1:0]];
  assign mem_wdata = fifo_empty ? '0 : data_mem[rd_ptr[PW-1:0]];

  assign busy = (state == S_ACTIVE) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    seen_next  = running_seen;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ACTIVE;
          seen_next  = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (chip_running) seen_next = 1'b1;
        if (running_seen && !chip_running) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_ptr_next == rd_ptr_next) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state        <= S_IDLE;
      running_seen <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      write_count  <= '0;
      drop_count   <= '0;
    end else begin
      state        <= state_next;
      running_seen <= seen_next;
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      if (state == S_IDLE && start) begin
        overflow    <= 1'b0;
        write_count <= '0;
        drop_count  <= '0;
      end else begin
        if (pop && write_count != '1) write_count <= write_count + 1'b1;
        if (push_drop) begin
          overflow <= 1'b1;
          if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      addr_mem[wr_ptr[PW-1:0]] <= push_addr;
      data_mem[wr_ptr[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_output_writeback;

  localparam int DW    = 16;
  localparam int FMW   = 1024;
  localparam int FMH   = 1024;
  localparam int NCH   = 64;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst_in, start, chip_running, in_valid, mem_ready;
  logic [DW-1:0] in_data;
  logic [9:0]    in_x;
  logic [9:0]    in_y;
  logic [5:0]    in_ch;
  logic          mem_we, busy, done, overflow;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [CW-1:0] write_count, drop_count;

  output_writeback #(
    .IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
    .OUTPUT_NB_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .chip_running(chip_running),
    .in_data(in_data), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .overflow(overflow),
    .write_count(write_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: layer phase, pending results in push order, and statistics.
  typedef enum int {M_IDLE, M_ACTIVE, M_DRAIN, M_DONE} phase_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  phase_t      m_phase;
  bit          m_seen;
  entry_t      m_q[$];
  bit          m_ovf;
  longint      m_wcnt, m_dcnt;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] d);
`ifdef OUTPUT_WRITEBACK_RELU_EN
    return ($signed(d) < 0) ? '0 : d;
`else
    return d;
`endif
  endfunction

  task automatic model_update();
    bit     had_head, full_before, pushing;
    longint a;
    entry_t e;
    if (rst_in) begin
      m_phase = M_IDLE; m_seen = 0; m_q.delete(); m_ovf = 0; m_wcnt = 0; m_dcnt = 0;
      return;
    end
    had_head    = (m_q.size() > 0);
    full_before = (m_q.size() == DEPTH);
    pushing     = in_valid && (m_phase == M_ACTIVE || m_phase == M_DRAIN);
    if (had_head && mem_ready) begin
      void'(m_q.pop_front());
      if (m_wcnt < 64'hFFFF_FFFF) m_wcnt++;
    end
    if (pushing) begin
      if (full_before && !(had_head && mem_ready)) begin
        m_ovf = 1;
        if (m_dcnt < 64'hFFFF_FFFF) m_dcnt++;
      end else begin
        a = ((longint'(in_y) * FMW + longint'(in_x)) * NCH + longint'(in_ch));
        e.addr = a[AW-1:0];
        e.data = relu_model(in_data);
        m_q.push_back(e);
      end
    end
    case (m_phase)
      M_IDLE: if (start) begin
        m_phase = M_ACTIVE; m_seen = 0; m_ovf = 0; m_wcnt = 0; m_dcnt = 0;
      end
      M_ACTIVE: begin
        if (m_seen && !chip_running) m_phase = M_DRAIN;
        if (chip_running) m_seen = 1;
      end
      M_DRAIN: if (m_q.size() == 0) m_phase = M_DONE;
      default: m_phase = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check("mem_we", mem_we, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("mem_addr", mem_addr, m_q[0].addr);
      check("mem_wdata", mem_wdata, m_q[0].data);
    end
    check("busy", busy, m_phase == M_ACTIVE || m_phase == M_DRAIN);
    check("done", done, m_phase == M_DONE);
    check("overflow", overflow, m_ovf);
    check("write_count", write_count, m_wcnt);
    check("drop_count", drop_count, m_dcnt);
  endtask

  // One clock: model consumes the driven inputs, DUT is compared on the falling edge.
  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic push(input int x, input int y, input int ch, input logic [DW-1:0] d);
    in_valid = 1; in_x = 10'(x); in_y = 10'(y); in_ch = 6'(ch); in_data = d;
    step();
    in_valid = 0;
  endtask

  task automatic push_rand();
    push($urandom_range(0, FMW-1), $urandom_range(0, FMH-1), $urandom_range(0, NCH-1),
         DW'($urandom));
  endtask

  task automatic begin_layer();
    start = 1; step(); start = 0;
    chip_running = 1; step();
  endtask

  task automatic finish_layer(input string tag);
    bit got_done = 0;
    chip_running = 0; mem_ready = 1; in_valid = 0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      step();
      if (done === 1'b1) got_done = 1;
    end
    check({tag, "_done_seen"}, got_done, 1'b1);
    step();
  endtask

  initial begin
    rst_in = 1; start = 0; chip_running = 0; in_valid = 0; mem_ready = 0;
    in_data = '0; in_x = '0; in_y = '0; in_ch = '0;
    @(negedge clk);
    step(); step();
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rst_in = 0;
    step();

    // Basic single write.
    begin_layer();
    mem_ready = 1;
    chip_running = 1;
    push(2, 1, 3, 16'h1234);
    check("basic_addr", mem_addr, 65667);
    check("basic_data", mem_wdata, 16'h1234);
    chip_running = 0;
    step();
    step();
    check("basic_done", done, 1'b1);
    check("basic_wcnt", write_count, 1);
    step();

    // Backpressure: 5 results held for 10 stalled cycles.
    begin_layer();
    mem_ready = 0;
    for (int i = 0; i < 5; i++) push_rand();
    for (int i = 0; i < 10; i++) step();
    finish_layer("bp");
    check("bp_wcnt", write_count, 5);
    check("bp_dcnt", drop_count, 0);

    // Overflow: 10 pushes into an 8-deep FIFO that never drains.
    begin_layer();
    mem_ready = 0;
    for (int i = 0; i < 10; i++) push_rand();
    check("ovf_flag", overflow, 1'b1);
    check("ovf_dcnt", drop_count, 2);
    finish_layer("ovf");
    check("ovf_wcnt", write_count, 8);

    // Full FIFO with a simultaneous pop accepts the push.
    begin_layer();
    mem_ready = 0;
    for (int i = 0; i < DEPTH; i++) push_rand();
    mem_ready = 1;
    push_rand();
    check("fullpop_dcnt", drop_count, 0);
    check("fullpop_ovf", overflow, 1'b0);
    finish_layer("fullpop");
    check("fullpop_wcnt", write_count, 9);

    // Reset with 4 entries queued.
    begin_layer();
    mem_ready = 0;
    for (int i = 0; i < 4; i++) push_rand();
    rst_in = 1; step(); rst_in = 0;
    chip_running = 0;
    check("midrst_we", mem_we, 1'b0);
    check("midrst_wcnt", write_count, 0);
    check("midrst_busy", busy, 1'b0);
    mem_ready = 1;
    for (int i = 0; i < 4; i++) step();

    // Negative result: clamped only with the RELU option.
    begin_layer();
    mem_ready = 0;
    push(5, 6, 7, 16'hFFFB);
`ifdef OUTPUT_WRITEBACK_RELU_EN
    check("relu_data", mem_wdata, 16'h0000);
`else
    check("relu_data", mem_wdata, 16'hFFFB);
`endif
    finish_layer("relu");

    // Randomized traffic including stalls, drops and pushes during drain.
    begin_layer();
    for (int i = 0; i < 400; i++) begin
      mem_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 1) == 1) push_rand();
      else step();
    end
    chip_running = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 0;
      push_rand();
    end
    finish_layer("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
